// File: rtl/acc_readout_mux_if.sv
// Bus bundle for acc_readout_mux: channel-side word fetch and consumer-side byte stream.
// Handshake: a byte moves on a cycle where DataReady and ReadEnable are both 1; while
// DataReady=1 and ReadEnable=0 the mux holds DataOut stable. ChRead is a one-cycle
// consume pulse, asserted only in a cycle where the matching ChReady is 1.
interface acc_readout_mux_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16
);
  logic [NUM_CH*DATA_W-1:0] ChData;
  logic [NUM_CH-1:0]        ChReady;
  logic [NUM_CH-1:0]        ChEnable;
  logic [NUM_CH-1:0]        ChRead;
  logic [7:0]               DataOut;
  logic                     DataReady;
  logic                     ReadEnable;
  logic                     FrameDone;

  modport master (
    input  ChData, ChReady, ChEnable, ReadEnable,
    output ChRead, DataOut, DataReady, FrameDone
  );

  modport slave (
    output ChData, ChReady, ChEnable, ReadEnable,
    input  ChRead, DataOut, DataReady, FrameDone
  );
endinterface

// File: rtl/acc_readout_mux.sv
// Reads SAMPLES words from each enabled accumulator channel in ascending order and streams
// them MSB byte first. Define ACC_READOUT_HEADER_EN to prefix each frame with 0xA5 and the mask.
module acc_readout_mux #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 16,
  parameter int SAMPLES = 512
) (
  input  logic              Clock,
  input  logic              Reset,
  acc_readout_mux_if.master bus,
  output logic [4:0]        dbg_state
);

  localparam int BYTES = DATA_W / 8;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int SC_W  = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

`ifdef ACC_READOUT_HEADER_EN
  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    LOAD   = 5'b00010,
    SHIFT  = 5'b00100,
    DONE   = 5'b01000,
    HEADER = 5'b10000
  } state_t;
`else
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    LOAD  = 5'b00010,
    SHIFT = 5'b00100,
    DONE  = 5'b01000
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] mask_q;
  logic [CH_W-1:0]   ch_q;
  logic [DATA_W-1:0] word_q;
  logic [BC_W-1:0]   byte_cnt_q;
  logic [SC_W-1:0]   sample_cnt_q;
`ifdef ACC_READOUT_HEADER_EN
  logic              hdr_sel_q;
`endif

  logic [CH_W-1:0]   next_ch;
  logic              has_next;
  logic              start;
  logic              word_end;
  logic              last_sample;
  logic [NUM_CH-1:0] ch_read;
  logic [7:0]        data_out;
  logic              data_ready;
  logic              frame_done;

  function automatic logic [CH_W-1:0] first_set(input logic [NUM_CH-1:0] m);
    first_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) first_set = CH_W'(i);
    end
  endfunction

  // Next enabled channel above ch_q; wraps to the lowest one when none is left.
  always_comb begin
    next_ch  = first_set(mask_q);
    has_next = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(ch_q))) begin
        next_ch  = CH_W'(i);
        has_next = 1'b1;
      end
    end
  end

  assign start       = (bus.ChEnable != '0) && ((bus.ChReady & bus.ChEnable) == bus.ChEnable);
  assign word_end    = (byte_cnt_q == BC_W'(BYTES - 1));
  assign last_sample = (sample_cnt_q == SC_W'(SAMPLES - 1));

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ch_read    = '0;
    data_out   = 8'h00;
    data_ready = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
`ifdef ACC_READOUT_HEADER_EN
          state_d = HEADER;
`else
          state_d = LOAD;
`endif
        end
      end
`ifdef ACC_READOUT_HEADER_EN
      HEADER: begin
        data_ready = 1'b1;
        data_out   = hdr_sel_q ? 8'(mask_q) : 8'hA5;
        if (bus.ReadEnable && hdr_sel_q) state_d = LOAD;
      end
`endif
      LOAD: begin
        if (bus.ChReady[ch_q]) begin
          ch_read[ch_q] = 1'b1;
          state_d       = SHIFT;
        end
      end
      SHIFT: begin
        data_ready = 1'b1;
        data_out   = word_q[DATA_W-1 -: 8];
        if (bus.ReadEnable && word_end) begin
          state_d = (!has_next && last_sample) ? DONE : LOAD;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      mask_q       <= '0;
      ch_q         <= '0;
      word_q       <= '0;
      byte_cnt_q   <= '0;
      sample_cnt_q <= '0;
`ifdef ACC_READOUT_HEADER_EN
      hdr_sel_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mask_q       <= bus.ChEnable;
            ch_q         <= first_set(bus.ChEnable);
            byte_cnt_q   <= '0;
            sample_cnt_q <= '0;
`ifdef ACC_READOUT_HEADER_EN
            hdr_sel_q    <= 1'b0;
`endif
          end
        end
`ifdef ACC_READOUT_HEADER_EN
        HEADER: begin
          if (bus.ReadEnable) hdr_sel_q <= 1'b1;
        end
`endif
        LOAD: begin
          if (bus.ChReady[ch_q]) begin
            word_q     <= bus.ChData[int'(ch_q)*DATA_W +: DATA_W];
            byte_cnt_q <= '0;
          end
        end
        SHIFT: begin
          if (bus.ReadEnable) begin
            word_q <= word_q << 8;
            if (word_end) begin
              byte_cnt_q <= '0;
              ch_q       <= next_ch;
              // A sample completes when the wrap back to the lowest channel happens.
              if (!has_next && !last_sample) sample_cnt_q <= sample_cnt_q + SC_W'(1);
            end else begin
              byte_cnt_q <= byte_cnt_q + BC_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ChRead    = ch_read;
  assign bus.DataOut   = data_out;
  assign bus.DataReady = data_ready;
  assign bus.FrameDone = frame_done;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_acc_readout_mux.sv
// Self-checking bench for acc_readout_mux (NUM_CH=4, DATA_W=16, SAMPLES=2): table vectors,
// hand sequences for stall and reset abort, and randomized frames against a queue model.
module tb_acc_readout_mux;
  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 16;
  localparam int SAMPLES = 2;
  localparam int BYTES   = DATA_W / 8;
  localparam int DEPTH   = 8;
`ifdef ACC_READOUT_HEADER_EN
  localparam int HDR_BYTES = 2;
`else
  localparam int HDR_BYTES = 0;
`endif

  logic       clk;
  logic       rst;
  logic [4:0] dbg_state;

  acc_readout_mux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  acc_readout_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SAMPLES(SAMPLES)) dut (
    .Clock     (clk),
    .Reset     (rst),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [7:0]        exp_q[$];
  int                exp_ch_q[$];
  logic [DATA_W-1:0] src_mem[NUM_CH][DEPTH];
  int                rd_idx[NUM_CH];
  int                checks = 0;
  int                failures = 0;

  typedef struct {
    logic [3:0]  en;
    int          re_mode;
    int          n;
    logic [63:0] b;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fill_const();
    logic [DATA_W-1:0] w[NUM_CH];
    w[0] = 16'h1122; w[1] = 16'h3344; w[2] = 16'h5566; w[3] = 16'h7788;
    for (int k = 0; k < NUM_CH; k++)
      for (int d = 0; d < DEPTH; d++) src_mem[k][d] = w[k];
  endtask

  task automatic push_header(input logic [3:0] en);
    if (HDR_BYTES != 0) begin
      exp_q.push_back(8'hA5);
      exp_q.push_back({4'h0, en});
    end
  endtask

  task automatic build_table_exp(input vec_t v);
    exp_q.delete();
    exp_ch_q.delete();
    push_header(v.en);
    for (int s = 0; s < SAMPLES; s++) begin
      for (int j = 0; j < v.n; j++) exp_q.push_back(v.b[63-8*j -: 8]);
      for (int k = 0; k < NUM_CH; k++) if (v.en[k]) exp_ch_q.push_back(k);
    end
  endtask

  // Reference model: every sample visits enabled channels low to high, word s of each channel.
  task automatic build_model_exp(input logic [3:0] en);
    exp_q.delete();
    exp_ch_q.delete();
    push_header(en);
    for (int s = 0; s < SAMPLES; s++)
      for (int k = 0; k < NUM_CH; k++)
        if (en[k]) begin
          exp_ch_q.push_back(k);
          for (int bi = BYTES - 1; bi >= 0; bi--) exp_q.push_back(src_mem[k][s][bi*8 +: 8]);
        end
  endtask

  task automatic drive_data();
    for (int k = 0; k < NUM_CH; k++) bus.ChData[k*DATA_W +: DATA_W] = src_mem[k][rd_idx[k]];
  endtask

  // re_mode: 0 always, 1 toggle, 2 random. rdy_mode: 0 all ready, 1 random, 2 stall stall_ch.
  task automatic run_frame(input logic [3:0] en, input int re_mode, input int rdy_mode, input int stall_ch);
    logic [3:0] rd_prev = '0;
    logic [7:0] held_b = '0;
    logic [7:0] b;
    bit held = 0, exp_gap = 0, done_due = 0, started = 0, finished = 0, re_t = 0, stalling;
    int bytes_left = 0, hdr_left = HDR_BYTES, stall_cnt = 0, cyc = 0, k;
    for (int i = 0; i < NUM_CH; i++) rd_idx[i] = 0;
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NUM_CH; i++) if (rd_prev[i]) rd_idx[i] = (rd_idx[i] + 1) % DEPTH;
      drive_data();
      bus.ChEnable = (started && rdy_mode == 1) ? 4'($urandom_range(0, 15)) : en;
      stalling = 0;
      if (rdy_mode == 1) begin
        for (int i = 0; i < NUM_CH; i++) bus.ChReady[i] = ($urandom_range(0, 3) != 0);
      end else begin
        bus.ChReady = 4'hF;
        if (rdy_mode == 2 && started && bytes_left == 0 && stall_cnt < 5 &&
            exp_ch_q.size() > 0 && exp_ch_q[0] == stall_ch) begin
          bus.ChReady[stall_ch] = 1'b0;
          stalling = 1;
        end
      end
      if (re_mode == 0)      bus.ReadEnable = 1'b1;
      else if (re_mode == 1) begin re_t = ~re_t; bus.ReadEnable = re_t; end
      else                   bus.ReadEnable = 1'($urandom_range(0, 1));
      #1;
      chk($onehot(dbg_state), "state_onehot", 32'(dbg_state), 32'(dbg_state));
      if (stalling) begin
        chk(!bus.DataReady && bus.ChRead == 0, "stall_quiet", {bus.ChRead, 3'b0, bus.DataReady}, 0);
        stall_cnt++;
      end
      if (exp_gap) begin
        chk(!bus.DataReady, "word_gap", 32'(bus.DataReady), 0);
        exp_gap = 0;
      end
      if (held) begin
        chk(bus.DataReady && bus.DataOut == held_b, "byte_hold", {bus.DataReady, bus.DataOut}, {1'b1, held_b});
        held = 0;
      end
      if (bus.ChRead != 0) begin
        chk($countones(bus.ChRead) == 1 && (bus.ChRead & ~en) == 0, "chread_mask", 32'(bus.ChRead), 32'(en));
        if (exp_ch_q.size() == 0) chk(0, "chread_extra", 32'(bus.ChRead), 0);
        else begin
          k = exp_ch_q.pop_front();
          chk(bus.ChRead == (4'b1 << k), "chread_order", 32'(bus.ChRead), 32'(4'b1 << k));
        end
        bytes_left = BYTES;
      end
      if (done_due) begin
        chk(bus.FrameDone, "frame_done", 32'(bus.FrameDone), 1);
        finished = 1;
      end else if (bus.FrameDone) begin
        chk(0, "frame_done_early", 32'(exp_q.size()), 0);
        finished = 1;
      end
      if (!finished && bus.DataReady && bus.ReadEnable) begin
        started = 1;
        if (exp_q.size() == 0) chk(0, "byte_extra", 32'(bus.DataOut), 0);
        else begin
          b = exp_q.pop_front();
          chk(bus.DataOut == b, "byte", 32'(bus.DataOut), 32'(b));
          if (exp_q.size() == 0) done_due = 1;
        end
        if (hdr_left > 0) begin
          hdr_left--;
          if (hdr_left == 0) exp_gap = 1;
        end else if (bytes_left > 0) begin
          bytes_left--;
          if (bytes_left == 0) exp_gap = 1;
        end
      end else if (!finished && bus.DataReady) begin
        held = 1;
        held_b = bus.DataOut;
      end
      rd_prev = bus.ChRead;
    end
    bus.ChEnable = 4'h0;
    bus.ReadEnable = 1'b0;
    if (!finished) chk(0, "frame_timeout", 32'(exp_q.size()), 0);
    if (rdy_mode == 2) chk(stall_cnt == 5, "stall_cycles", 32'(stall_cnt), 5);
    @(negedge clk);
    #1;
    chk(!bus.DataReady && !bus.FrameDone, "after_done_idle", {bus.DataReady, bus.FrameDone}, 0);
  endtask

  task automatic reset_abort();
    int acc = 0, cyc = 0;
    logic [7:0] first3[3];
    build_table_exp(vecs[0]);
    for (int i = 0; i < 3; i++) first3[i] = exp_q[i];
    fill_const();
    for (int i = 0; i < NUM_CH; i++) rd_idx[i] = 0;
    drive_data();
    bus.ChEnable = 4'hF;
    bus.ChReady = 4'hF;
    bus.ReadEnable = 1'b1;
    while (acc < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      #1;
      if (bus.DataReady && bus.ReadEnable) begin
        chk(bus.DataOut == first3[acc], "abort_prefix", 32'(bus.DataOut), 32'(first3[acc]));
        acc++;
      end
    end
    if (acc < 3) chk(0, "abort_timeout", 32'(acc), 3);
    @(negedge clk);
    rst = 1'b1;
    bus.ChEnable = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk(!bus.DataReady && bus.DataOut == 0 && bus.ChRead == 0 && !bus.FrameDone, "abort_outputs",
        {bus.DataOut, bus.ChRead, bus.DataReady, bus.FrameDone}, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk(!bus.FrameDone && !bus.DataReady && bus.ChRead == 0, "abort_quiet",
          {bus.ChRead, bus.DataReady, bus.FrameDone}, 0);
    end
    build_table_exp(vecs[0]);
    run_frame(vecs[0].en, vecs[0].re_mode, 0, -1);
  endtask

  initial begin
    vecs[0] = '{4'hF, 0, 8, 64'h1122334455667788};
    vecs[1] = '{4'hA, 0, 4, 64'h3344778800000000};
    vecs[2] = '{4'hF, 1, 8, 64'h1122334455667788};
    vecs[3] = '{4'h5, 2, 4, 64'h1122556600000000};
    vecs[4] = '{4'h8, 1, 2, 64'h7788000000000000};
    vecs[5] = '{4'h6, 0, 4, 64'h3344556600000000};

    rst = 1'b1;
    bus.ChData = '0;
    bus.ChReady = '0;
    bus.ChEnable = '0;
    bus.ReadEnable = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk(!bus.DataReady && bus.DataOut == 0 && bus.ChRead == 0 && !bus.FrameDone, "reset_outputs",
        {bus.DataOut, bus.ChRead, bus.DataReady, bus.FrameDone}, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.ReadEnable = 1'b0;
    @(negedge clk);
    #1;
    chk(!bus.DataReady && !bus.FrameDone, "idle_no_enable", {bus.DataReady, bus.FrameDone}, 0);

    for (int i = 0; i < 6; i++) begin
      fill_const();
      build_table_exp(vecs[i]);
      run_frame(vecs[i].en, vecs[i].re_mode, 0, -1);
    end

    fill_const();
    build_table_exp(vecs[0]);
    run_frame(4'hF, 0, 2, 2);

    reset_abort();

    for (int f = 0; f < 20; f++) begin
      logic [3:0] en;
      en = 4'($urandom_range(1, 15));
      for (int k = 0; k < NUM_CH; k++)
        for (int d = 0; d < DEPTH; d++) src_mem[k][d] = DATA_W'($urandom);
      build_model_exp(en);
      run_frame(en, 2, 1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/acc_readout_mux.md
ACC_READOUT_MUX -- requirements
Module: acc_readout_mux

Interface
REQ-001 Parameter NUM_CH, default 4: number of accumulator channels; legal 1..8.
REQ-002 Parameter DATA_W, default 16: width of one channel sample word; multiple of 8, legal 8..32.
REQ-003 Parameter SAMPLES, default 512: words read from each enabled channel per frame; legal 1..65535.
REQ-004 Clock  in  1  single clock; all logic on rising edge; reset is synchronous and active-high.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 ChData  in  NUM_CH*DATA_W  channel k word at bits [k*DATA_W +: DATA_W].
REQ-007 ChReady  in  NUM_CH  channel k has a word available.
REQ-008 ChEnable  in  NUM_CH  channel include mask; sampled at frame start only.
REQ-009 ChRead  out  NUM_CH  one-cycle pulse: channel k word consumed, advance to next.
REQ-010 DataOut  out  8  current output byte; valid only while DataReady=1.
REQ-011 DataReady  out  1  DataOut holds a valid byte.
REQ-012 ReadEnable  in  1  consumer takes DataOut this cycle; ignored when DataReady=0.
REQ-013 FrameDone  out  1  one-cycle pulse after final byte of a frame is taken.

Function
REQ-014 States SHALL be IDLE, LOAD, SHIFT, DONE (plus HEADER, see Configuration); one-hot encoding.
REQ-015 IDLE -> LOAD SHALL occur when ChEnable!=0 and (ChReady & ChEnable)==ChEnable; ChEnable latched into mask_q on that edge.
REQ-016 Channel order SHALL be ascending index over set bits of mask_q, wrapping from highest enabled channel to lowest enabled channel.
REQ-017 LOAD: when ChReady[ch]=1, word_q <= channel ch word, ChRead[ch] pulses that same cycle, -> SHIFT; when ChReady[ch]=0, stay in LOAD, no ChRead.
REQ-018 SHIFT: DataReady=1, DataOut = word_q[DATA_W-1 -: 8] (MSB byte first, driven from register).
REQ-019 Accepted byte (ReadEnable & DataReady) SHALL shift word_q left 8 bits; next byte valid on the following cycle with no gap.
REQ-020 After DATA_W/8 accepted bytes, SHALL go to LOAD of next enabled channel; DataReady low for at least one cycle between words.
REQ-021 Sample counter SHALL increment after the last enabled channel's word finishes; at SAMPLES it SHALL go to DONE instead of LOAD.
REQ-022 DONE: FrameDone=1 for one cycle, -> IDLE; ChRead never pulses in DONE or IDLE.
REQ-023 ChEnable changes mid-frame SHALL have no effect until the next IDLE -> LOAD transition.
REQ-024 ChRead SHALL be at most one-hot and SHALL never assert for a channel outside mask_q.
REQ-025 Counter widths SHALL be $clog2 sized; no wrap inside a frame.

Reset
REQ-026 Reset SHALL force IDLE, clear word_q, sample and byte counters, mask_q; DataReady=0, ChRead=0, FrameDone=0, DataOut=0 on the next cycle.
REQ-027 Reset mid-frame SHALL abort with no further ChRead pulse and no FrameDone pulse; Reset overrides ReadEnable in the same cycle.

Configuration
REQ-028 Macro ACC_READOUT_HEADER_EN defined: IDLE -> HEADER emitting 0xA5 then {mask_q zero-extended to 8 bits} under the same handshake, then -> LOAD; frame grows by 2 bytes.
REQ-029 Macro ACC_READOUT_HEADER_EN undefined: no HEADER state; IDLE -> LOAD directly; first byte of the frame is channel word MSB.

Verification
REQ-030 NUM_CH=4, DATA_W=16, SAMPLES=2, ChEnable=4'hF, all ready, ChData ch0..3 = 0x1122,0x3344,0x5566,0x7788, ReadEnable=1 -> bytes 11 22 33 44 55 66 77 88 twice, 4 ChRead pulses per sample, one FrameDone.
REQ-031 ChEnable=4'b1010, SAMPLES=1 -> only ch1 then ch3 bytes; ChRead[0] and ChRead[2] stay 0; FrameDone after 4 bytes.
REQ-032 ChReady[2]=0 for 5 cycles while in LOAD for ch2 -> DataReady=0 for those cycles, no ChRead, resumes with ch2 MSB once ChReady[2]=1.
REQ-033 ReadEnable toggled 1/0 each cycle -> each byte held stable until accepted; byte sequence identical to REQ-030.
REQ-034 Reset asserted after 3rd byte of a frame -> DataReady=0 next cycle, no FrameDone; new frame restarts at ch0 MSB.
REQ-035 ACC_READOUT_HEADER_EN defined, ChEnable=4'h5 -> first bytes A5 05, then ch0 and ch2 words.
